alg_amba_vip_base_fault_ctrl: RTL and testbench

// - Campaign sequencer for one AMBA VIP fault-injector instance; sits beside the injector in the allegro tb.
// - Holds a table of fault steps and runs them in order. Each step: restart/seed, then inject until a request count is reached.
// - Reports per-step error/request counts to the bench, then returns the injector to pass-through.

---
 rtl/alg_amba_vip_base_fault_pkg.sv | 55 +++++
 rtl/alg_amba_vip_base_fault_steptbl.sv | 29 ++
 rtl/alg_amba_vip_base_fault_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_alg_amba_vip_base_fault_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alg_amba_vip_base_fault_pkg.sv
// Shared types and constants for the AMBA VIP fault-campaign sequencer.
// Holds the step-table entry layout, the controller state encoding,
// the injector command codes and the cfg_wdata field offsets.
package alg_amba_vip_base_fault_pkg;

  // The stored id field is fixed-width; the top keeps its low ID_WIDTH bits (ID_WIDTH <= 8).
  localparam int unsigned STEP_ID_W = 8;

  // cfg_wdata field offsets
  localparam int unsigned CFG_SEED_LSB  = 0;
  localparam int unsigned CFG_THRES_LSB = 20;
  localparam int unsigned CFG_CMD_LSB   = 40;
  localparam int unsigned CFG_LEN_LSB   = 44;

  // Injector command codes
  localparam logic [3:0] FAULT_CMD_NONE      = 4'h0;
  localparam logic [3:0] FAULT_CMD_FLIPBIT   = 4'h1;
  localparam logic [3:0] FAULT_CMD_STUCK0    = 4'h2;
  localparam logic [3:0] FAULT_CMD_STUCK1    = 4'h3;
  localparam logic [3:0] FAULT_CMD_DROP      = 4'h4;
  localparam logic [3:0] FAULT_CMD_DELAY     = 4'h5;
  localparam logic [3:0] FAULT_CMD_DUPLICATE = 4'h6;
  localparam logic [3:0] FAULT_CMD_XORPAT    = 4'h7;
  localparam logic [3:0] FAULT_CMD_REPLACE   = 4'h8;
  localparam logic [3:0] FAULT_CMD_TRUNCATE  = 4'h9;
  localparam logic [3:0] FAULT_CMD_SWAPBYTE  = 4'hA;

  typedef struct packed {
    logic [19:0]          seed;
    logic [19:0]          thres;
    logic [3:0]           cmd;
    logic [STEP_ID_W-1:0] id;
    logic [15:0]          length;
  } step_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } ctrl_state_e;

  // Unpacks the used part of a cfg_wdata word plus the target id into a table entry.
  function automatic step_t decodeStep(input logic [59:0] wdata, input logic [STEP_ID_W-1:0] id);
    step_t s;
    s.seed   = wdata[CFG_SEED_LSB  +: 20];
    s.thres  = wdata[CFG_THRES_LSB +: 20];
    s.cmd    = wdata[CFG_CMD_LSB   +: 4];
    s.id     = id;
    s.length = wdata[CFG_LEN_LSB   +: 16];
    return s;
  endfunction

endpackage

// File: rtl/alg_amba_vip_base_fault_steptbl.sv
// Step table for the fault-campaign sequencer: NB_STEPS entries,
// one synchronous write port and a combinational read port.
// Contents are deliberately not reset; the bench must program before use.
module alg_amba_vip_base_fault_steptbl
  import alg_amba_vip_base_fault_pkg::*;
#(
  parameter int NB_STEPS = 8,
  localparam int AW = $clog2(NB_STEPS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  step_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output step_t         o_rdata
);

  step_t r_mem [NB_STEPS];

  // Single write port; the controller only enables it while not busy.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alg_amba_vip_base_fault_ctrl.sv
// Campaign sequencer for one AMBA VIP fault injector.
// Runs the programmed steps in order: restart/seed the injector, let it
// inject until the request count reaches the step length, report the
// stats, then return the injector to pass-through.
// Optional build macro: ALG_FAULT_CTRL_LOOP_EN adds i_loop, which wraps the
// campaign back to step 0 instead of finishing.
module alg_amba_vip_base_fault_ctrl
  import alg_amba_vip_base_fault_pkg::*;
#(
  parameter int NB_STEPS    = 8,
  parameter int ID_WIDTH    = 1,
  parameter int FAULT_WIDTH = 128,
  localparam int AW = $clog2(NB_STEPS)
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_cfg_we,
  input  logic [AW-1:0]          i_cfg_addr,
  input  logic [63:0]            i_cfg_wdata,
  input  logic [ID_WIDTH-1:0]    i_cfg_wid,
  input  logic [FAULT_WIDTH-1:0] i_cfg_pattern,
  input  logic [AW:0]            i_nb_steps,
  input  logic                   i_start,
  input  logic                   i_abort,
`ifdef ALG_FAULT_CTRL_LOOP_EN
  input  logic                   i_loop,
`endif
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_cfg_err,
  output logic [AW-1:0]          o_step_idx,
  output logic                   o_restart,
  output logic [19:0]            o_seed,
  output logic [19:0]            o_probThresReq,
  output logic [3:0]             o_cmd,
  output logic [ID_WIDTH-1:0]    o_id,
  output logic [FAULT_WIDTH-1:0] o_regPattern,
  input  logic [31:0]            i_stats_nbrequest,
  input  logic [31:0]            i_stats_nberror,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [AW-1:0]          o_res_step,
  output logic [31:0]            o_res_nbrequest,
  output logic [31:0]            o_res_nberror
);

  ctrl_state_e            r_state;
  ctrl_state_e            w_stateNext;
  ctrl_state_e            w_advState;
  logic [AW-1:0]          r_stepIdx;
  logic [AW-1:0]          w_stepNext;
  logic [AW-1:0]          w_advStep;
  logic [AW:0]            r_nbSteps;
  logic [FAULT_WIDTH-1:0] r_pattern;
  logic [31:0]            r_statsReq;
  logic [31:0]            r_statsErr;
  logic [AW-1:0]          r_resStep;
  logic [31:0]            r_resReq;
  logic [31:0]            r_resErr;
  logic                   r_cfgErr;
  logic                   w_startGo;
  logic                   w_resLatch;
  logic                   w_busy;
  logic                   w_active;
  logic                   w_isLast;
  logic                   w_lenZero;
  logic                   w_runHit;
  logic                   w_loop;
  logic                   w_cfgWrite;
  step_t                  w_wrEntry;
  step_t                  w_entry;
  logic                   w_unused;

`ifdef ALG_FAULT_CTRL_LOOP_EN
  assign w_loop = i_loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_busy     = (r_state == ST_LOAD) || (r_state == ST_RUN) || (r_state == ST_REPORT);
  assign w_active   = (r_state == ST_LOAD) || (r_state == ST_RUN);
  assign w_cfgWrite = i_cfg_we && !w_busy;
  assign w_wrEntry  = decodeStep(i_cfg_wdata[59:0], STEP_ID_W'(i_cfg_wid));

  alg_amba_vip_base_fault_steptbl #(
    .NB_STEPS (NB_STEPS)
  ) u_steptbl (
    .i_clk   (i_clk),
    .i_we    (w_cfgWrite),
    .i_waddr (i_cfg_addr),
    .i_wdata (w_wrEntry),
    .i_raddr (r_stepIdx),
    .o_rdata (w_entry)
  );

  // Reserved wdata bits and the zero-extended id bits are intentionally ignored.
  assign w_unused = ^{i_cfg_wdata[63:60], w_entry.id};

  assign w_isLast  = ({1'b0, r_stepIdx} == (r_nbSteps - (AW+1)'(1)));
  assign w_lenZero = (w_entry.length == 16'd0);
  assign w_runHit  = (r_statsReq >= {16'd0, w_entry.length});
  assign w_advState = (w_isLast && !w_loop) ? ST_DONE : ST_LOAD;
  assign w_advStep  = w_isLast ? '0 : (r_stepIdx + AW'(1));

  // State register; reset is synchronous so a mid-campaign rstn drop lands next edge.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and injector-facing outputs; abort overrides everything else.
  always_comb begin
    w_stateNext    = r_state;
    w_stepNext     = r_stepIdx;
    w_startGo      = 1'b0;
    w_resLatch     = 1'b0;
    o_restart      = 1'b0;
    o_seed         = '0;
    o_probThresReq = '0;
    o_cmd          = FAULT_CMD_NONE;
    o_id           = '0;
    o_regPattern   = '0;
    o_busy         = w_busy;
    o_done         = (r_state == ST_DONE);
    o_res_valid    = (r_state == ST_REPORT);

    if (w_active) begin
      o_seed         = w_entry.seed;
      o_probThresReq = w_entry.thres;
      o_cmd          = w_entry.cmd;
      o_id           = ID_WIDTH'(w_entry.id);
      o_regPattern   = r_pattern;
    end
    if (r_state == ST_LOAD) begin
      o_restart = !w_lenZero;
    end

    if (i_abort) begin
      w_stateNext = ST_IDLE;
      w_stepNext  = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            w_startGo = 1'b1;
            if (i_nb_steps == '0) begin
              w_stateNext = ST_DONE;
            end else begin
              w_stateNext = ST_LOAD;
              w_stepNext  = '0;
            end
          end
        end
        ST_LOAD: begin
          if (w_lenZero) begin
            w_stateNext = w_advState;
            w_stepNext  = w_advStep;
          end else begin
            w_stateNext = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_runHit) begin
            w_stateNext = ST_REPORT;
            w_resLatch  = 1'b1;
          end
        end
        ST_REPORT: begin
          if (i_res_ready) begin
            w_stateNext = w_advState;
            w_stepNext  = w_advStep;
          end
        end
        default: begin
          w_stateNext = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath registers: step index, campaign snapshot, registered stats and results.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_stepIdx  <= '0;
      r_nbSteps  <= '0;
      r_pattern  <= '0;
      r_statsReq <= '0;
      r_statsErr <= '0;
      r_resStep  <= '0;
      r_resReq   <= '0;
      r_resErr   <= '0;
      r_cfgErr   <= 1'b0;
    end else begin
      r_stepIdx <= w_stepNext;
      if (r_state == ST_LOAD) begin
        r_statsReq <= '0;
        r_statsErr <= '0;
      end else begin
        r_statsReq <= i_stats_nbrequest;
        r_statsErr <= i_stats_nberror;
      end
      if (i_abort) begin
        r_pattern <= '0;
      end else if (w_startGo) begin
        r_nbSteps <= i_nb_steps;
        r_pattern <= i_cfg_pattern;
      end
      if (w_resLatch) begin
        r_resStep <= r_stepIdx;
        r_resReq  <= r_statsReq;
        r_resErr  <= r_statsErr;
      end
      if (w_startGo) begin
        r_cfgErr <= 1'b0;
      end else if (i_cfg_we && w_busy) begin
        r_cfgErr <= 1'b1;
      end
    end
  end

  assign o_cfg_err       = r_cfgErr;
  assign o_step_idx      = r_stepIdx;
  assign o_res_step      = r_resStep;
  assign o_res_nbrequest = r_resReq;
  assign o_res_nberror   = r_resErr;

endmodule

// File: tb/tb_alg_amba_vip_base_fault_ctrl.sv
// Directed bench for alg_amba_vip_base_fault_ctrl with a small injector model.
// Optional build macro: ALG_FAULT_CTRL_LOOP_EN enables the looping scenario.
module tb_alg_amba_vip_base_fault_ctrl;

  localparam int AW  = 3;
  localparam int IDW = 1;
  localparam int FW  = 128;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [63:0]   cfg_wdata;
  logic [IDW-1:0] cfg_wid;
  logic [FW-1:0] cfg_pattern;
  logic [AW:0]   nb_steps;
  logic          start;
  logic          abort;
`ifdef ALG_FAULT_CTRL_LOOP_EN
  logic          loop;
`endif
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [AW-1:0] step_idx;
  logic          restart;
  logic [19:0]   seed;
  logic [19:0]   probThresReq;
  logic [3:0]    cmd;
  logic [IDW-1:0] id;
  logic [FW-1:0] regPattern;
  logic [31:0]   injReq;
  logic [31:0]   injErr;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_step;
  logic [31:0]   res_nbrequest;
  logic [31:0]   res_nberror;

  logic          trafficEn;
  int            checks = 0;
  int            errors = 0;
  int            restartCnt = 0;

  always #5 clk = ~clk;

  alg_amba_vip_base_fault_ctrl #(
    .NB_STEPS    (8),
    .ID_WIDTH    (IDW),
    .FAULT_WIDTH (FW)
  ) dut (
    .i_clk             (clk),
    .i_rstn            (rstn),
    .i_cfg_we          (cfg_we),
    .i_cfg_addr        (cfg_addr),
    .i_cfg_wdata       (cfg_wdata),
    .i_cfg_wid         (cfg_wid),
    .i_cfg_pattern     (cfg_pattern),
    .i_nb_steps        (nb_steps),
    .i_start           (start),
    .i_abort           (abort),
`ifdef ALG_FAULT_CTRL_LOOP_EN
    .i_loop            (loop),
`endif
    .o_busy            (busy),
    .o_done            (done),
    .o_cfg_err         (cfg_err),
    .o_step_idx        (step_idx),
    .o_restart         (restart),
    .o_seed            (seed),
    .o_probThresReq    (probThresReq),
    .o_cmd             (cmd),
    .o_id              (id),
    .o_regPattern      (regPattern),
    .i_stats_nbrequest (injReq),
    .i_stats_nberror   (injErr),
    .o_res_valid       (res_valid),
    .i_res_ready       (res_ready),
    .o_res_step        (res_step),
    .o_res_nbrequest   (res_nbrequest),
    .o_res_nberror     (res_nberror)
  );

  // Injector model: one request per cycle while traffic runs; every request
  // is faulted when a non-zero command has a non-zero threshold.
  always @(posedge clk) begin
    if (!rstn || restart) begin
      injReq <= 32'd0;
      injErr <= 32'd0;
    end else if (trafficEn) begin
      injReq <= injReq + 32'd1;
      if (cmd != 4'h0 && probThresReq != 20'h0) begin
        injErr <= injErr + 32'd1;
      end
    end
  end

  // Counts restart pulses seen by the injector.
  always @(posedge clk) begin
    if (rstn && restart) begin
      restartCnt <= restartCnt + 1;
    end
  end

  // Hard stop in case a wait somewhere never returns.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic writeStep(input logic [AW-1:0] idx, input logic [19:0] sd, input logic [19:0] th,
                           input logic [3:0] cm, input logic [15:0] len, input logic [IDW-1:0] wid);
    cfg_we    = 1'b1;
    cfg_addr  = idx;
    cfg_wdata = {4'h0, len, cm, th, sd};
    cfg_wid   = wid;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic applyStimulus(input logic doStart, input logic doAbort);
    start = doStart;
    abort = doAbort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic waitResult(input string tag, input int maxCycles);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, res_valid, 1);
  endtask

  task automatic checkResult(input string tag, input logic [AW-1:0] stp, input logic [31:0] req, input logic [31:0] err);
    waitResult(tag, 200);
    checkOutput({tag, "_step"}, res_step, stp);
    checkOutput({tag, "_nbrequest"}, res_nbrequest, req);
    checkOutput({tag, "_nberror"}, res_nberror, err);
    checkOutput({tag, "_cmd_off"}, cmd, 0);
    checkOutput({tag, "_thres_off"}, probThresReq, 0);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    logic        anyActive;
    logic [31:0] errSnap;
    int          rc0;

    rstn        = 1'b0;
    cfg_we      = 1'b0;
    cfg_addr    = '0;
    cfg_wdata   = '0;
    cfg_wid     = '0;
    cfg_pattern = '0;
    nb_steps    = '0;
    start       = 1'b0;
    abort       = 1'b0;
    res_ready   = 1'b0;
    trafficEn   = 1'b0;
`ifdef ALG_FAULT_CTRL_LOOP_EN
    loop        = 1'b0;
`endif
    tick(3);
    rstn = 1'b1;
    @(negedge clk);

    // Reset state and 100 idle cycles
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_restart", restart, 0);
    checkOutput("rst_cmd", cmd, 0);
    checkOutput("rst_thres", probThresReq, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_step_idx", step_idx, 0);
    anyActive = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      anyActive = anyActive | busy | done | restart | res_valid | cfg_err | (cmd != 4'h0) | (probThresReq != 20'h0);
    end
    checkOutput("idle100_quiet", anyActive, 0);

    // Two-step campaign
    trafficEn = 1'b1;
    writeStep(3'd0, 20'h12345, 20'hFFFFF, 4'h1, 16'd10, 1'b1);
    writeStep(3'd1, 20'h00ABC, 20'h00000, 4'h7, 16'd5, 1'b0);
    cfg_pattern = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    nb_steps    = 4'd2;
    rc0         = restartCnt;
    applyStimulus(1'b1, 1'b0);
    checkOutput("c1_restart_lat", restart, 1);
    checkOutput("c1_busy", busy, 1);
    checkOutput("c1_step_idx", step_idx, 0);
    checkOutput("c1_cmd", cmd, 1);
    checkOutput("c1_thres", probThresReq, 20'hFFFFF);
    checkOutput("c1_seed", seed, 20'h12345);
    checkOutput("c1_id", id, 1);
    checkOutput("c1_pattern", regPattern, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
    @(negedge clk);
    checkOutput("c1_restart_1cyc", restart, 0);
    checkOutput("c1_run_cmd", cmd, 1);
    checkResult("c1_r0", 3'd0, 32'd10, 32'd10);
    handshake();
    checkResult("c1_r1", 3'd1, 32'd5, 32'd0);
    handshake();
    checkOutput("c1_done", done, 1);
    checkOutput("c1_busy_end", busy, 0);
    checkOutput("c1_restarts", restartCnt - rc0, 2);

    // Zero-length middle step is skipped; REPORT held with res_ready low
    writeStep(3'd0, 20'h00001, 20'h00001, 4'h2, 16'd4, 1'b0);
    writeStep(3'd1, 20'h00002, 20'h00002, 4'h3, 16'd0, 1'b0);
    writeStep(3'd2, 20'h00003, 20'h00000, 4'h0, 16'd3, 1'b1);
    nb_steps = 4'd3;
    rc0      = restartCnt;
    applyStimulus(1'b1, 1'b0);
    checkOutput("c2_done_cleared", done, 0);
    checkResult("c2_r0", 3'd0, 32'd4, 32'd4);
    errSnap = injErr;
    tick(20);
    checkOutput("hold_valid", res_valid, 1);
    checkOutput("hold_step", res_step, 0);
    checkOutput("hold_nbrequest", res_nbrequest, 4);
    checkOutput("hold_nberror", res_nberror, 4);
    checkOutput("hold_cmd", cmd, 0);
    checkOutput("hold_inj_err_frozen", injErr, errSnap);
    handshake();
    checkResult("c2_r2", 3'd2, 32'd3, 32'd0);
    handshake();
    checkOutput("c2_done", done, 1);
    checkOutput("c2_no_extra_valid", res_valid, 0);
    checkOutput("c2_restarts", restartCnt - rc0, 2);

    // Config write while busy is dropped and flagged
    writeStep(3'd0, 20'h00010, 20'h00005, 4'h3, 16'd6, 1'b0);
    writeStep(3'd1, 20'h00020, 20'h000FF, 4'h4, 16'd8, 1'b1);
    nb_steps = 4'd2;
    applyStimulus(1'b1, 1'b0);
    tick(3);
    writeStep(3'd1, 20'h00099, 20'h00000, 4'h9, 16'd2, 1'b0);
    checkOutput("cfgerr_set", cfg_err, 1);
    checkResult("c3_r0", 3'd0, 32'd6, 32'd6);
    handshake();
    checkResult("c3_r1", 3'd1, 32'd8, 32'd8);
    handshake();
    checkOutput("c3_done", done, 1);
    checkOutput("c3_cfgerr_sticky", cfg_err, 1);

    // Rerun, then abort during RUN of step 1
    applyStimulus(1'b1, 1'b0);
    checkOutput("c4_cfgerr_cleared", cfg_err, 0);
    checkResult("c4_r0", 3'd0, 32'd6, 32'd6);
    handshake();
    tick(2);
    checkOutput("c4_run_step", step_idx, 1);
    checkOutput("c4_run_seed", seed, 20'h00020);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_valid", res_valid, 0);
    checkOutput("abort_cmd", cmd, 0);
    checkOutput("abort_restart", restart, 0);
    checkOutput("abort_pattern", regPattern, 0);
    rc0 = restartCnt;
    anyActive = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      anyActive = anyActive | restart | res_valid | busy;
    end
    checkOutput("abort_quiet", anyActive, 0);
    checkOutput("abort_no_restart", restartCnt - rc0, 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_after_start", restart, 1);
    @(negedge clk);
    checkOutput("restart_count_after_start", restartCnt - rc0, 1);

    // Synchronous reset mid-campaign
    tick(2);
    rstn = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_cmd", cmd, 0);
    checkOutput("midrst_step", step_idx, 0);
    rstn = 1'b1;
    @(negedge clk);

    // nb_steps == 0 finishes immediately
    nb_steps = 4'd0;
    rc0      = restartCnt;
    applyStimulus(1'b1, 1'b0);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_busy", busy, 0);
    tick(3);
    checkOutput("zero_no_restart", restartCnt - rc0, 0);

`ifdef ALG_FAULT_CTRL_LOOP_EN
    // Looping campaign wraps back to step 0
    writeStep(3'd0, 20'h00001, 20'h00001, 4'h1, 16'd3, 1'b0);
    writeStep(3'd1, 20'h00002, 20'h00000, 4'h0, 16'd2, 1'b0);
    nb_steps = 4'd2;
    loop     = 1'b1;
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      waitResult($sformatf("loop%0d", k), 200);
      checkOutput($sformatf("loop%0d_step", k), res_step, 3'(k % 2));
      handshake();
    end
    checkOutput("loop_busy", busy, 1);
    checkOutput("loop_not_done", done, 0);
    applyStimulus(1'b0, 1'b1);
    loop = 1'b0;
    checkOutput("loop_abort_idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
